riscv_single_cycle_processor: RTL and testbench

RISCV_SINGLE_CYCLE_PROCESSOR -- requirements
Module: riscv_single_cycle_processor

---
 rtl/riscv_single_cycle_processor.sv | 188 ++++++++++++++++++
 tb/tb_riscv_single_cycle_processor.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_single_cycle_processor.sv
// RV32I-subset single-cycle core: one instruction retires per rising clock edge.
// Instruction and data memories are internal; everything is observed through the hierarchy.
module riscv_imem #(
    parameter int WORDS = 256
) (
    input  logic [31:0] addr,
    output logic [31:0] rdata
);
    localparam int AW = $clog2(WORDS);

    logic [31:0] mem [0:WORDS-1];
    logic [29:0] widx;
    logic        unused_bits;

    assign widx        = addr[31:2] % 30'(WORDS);
    assign rdata       = mem[widx[AW-1:0]];
    assign unused_bits = ^{widx[29:AW], addr[1:0]};
endmodule

module riscv_dmem #(
    parameter int WORDS = 256
) (
    input  logic        clk,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int AW = $clog2(WORDS);

    logic [31:0] mem [0:WORDS-1];
    logic [29:0] widx;
    logic        unused_bits;

    assign widx        = addr[31:2] % 30'(WORDS);
    assign rdata       = re ? mem[widx[AW-1:0]] : '0;
    assign unused_bits = ^{widx[29:AW], addr[1:0]};

    always_ff @(posedge clk) begin
        if (we) mem[widx[AW-1:0]] <= wdata;
    end
endmodule

module riscv_single_cycle_processor #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256
) (
    input logic clk,
    input logic rst
);
    logic [31:0] pc_current, pc_next, pc_plus4;
    logic [31:0] instruction, alu_result, write_back_data;
    logic        RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg, Branch;

    logic [31:0] regs [0:31];
    logic [31:0] rs1_data, rs2_data, op_b, mem_rdata;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2, shamt;
    logic [2:0]  funct3;
    logic        alt, taken;
    logic        is_r, is_i, is_lw, is_sw, is_br, is_jal, is_jalr, is_lui;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign alt    = instruction[30];

    assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};
    assign imm_u = {instruction[31:12], 12'b0};

    assign is_r    = opcode == 7'h33;
    assign is_i    = opcode == 7'h13;
    assign is_lw   = opcode == 7'h03;
    assign is_sw   = opcode == 7'h23;
    assign is_br   = opcode == 7'h63 && funct3[2:1] == 2'b00;
    assign is_jal  = opcode == 7'h6f;
    assign is_jalr = opcode == 7'h67;
    assign is_lui  = opcode == 7'h37;

    riscv_imem #(.WORDS(IMEM_WORDS)) IMEM (
        .addr  (pc_current),
        .rdata (instruction)
    );

    // Anything not matched falls to the default and runs as a NOP.
    always_comb begin
        RegWrite = 1'b0;
        ALUSrc   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        Branch   = 1'b0;
        unique case (1'b1)
            is_r: RegWrite = 1'b1;
            is_i, is_lui, is_jalr: begin
                RegWrite = 1'b1;
                ALUSrc   = 1'b1;
            end
            is_lw: begin
                RegWrite = 1'b1;
                ALUSrc   = 1'b1;
                MemRead  = 1'b1;
                MemtoReg = 1'b1;
            end
            is_sw: begin
                ALUSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            is_br:  Branch   = 1'b1;
            is_jal: RegWrite = 1'b1;
            default: ;
        endcase
    end

    assign rs1_data = regs[rs1];
    assign rs2_data = regs[rs2];
    assign op_b     = ALUSrc ? (is_sw ? imm_s : imm_i) : rs2_data;
    assign shamt    = op_b[4:0];

    always_comb begin
        alu_result = rs1_data + op_b;
        if (is_lui) begin
            alu_result = imm_u;
        end else if (is_r || is_i) begin
            unique case (funct3)
                3'd0: alu_result = (is_r && alt) ? rs1_data - op_b : rs1_data + op_b;
                3'd1: alu_result = rs1_data << shamt;
                3'd2: alu_result = {31'b0, $signed(rs1_data) < $signed(op_b)};
                3'd3: alu_result = {31'b0, rs1_data < op_b};
                3'd4: alu_result = rs1_data ^ op_b;
                3'd5: alu_result = alt ? 32'($signed(rs1_data) >>> shamt)
                                       : rs1_data >> shamt;
                3'd6: alu_result = rs1_data | op_b;
                3'd7: alu_result = rs1_data & op_b;
                default: ;
            endcase
        end
    end

    // Stores are held off while reset is asserted.
    riscv_dmem #(.WORDS(DMEM_WORDS)) DMEM (
        .clk   (clk),
        .addr  (alu_result),
        .we    (MemWrite & rst),
        .re    (MemRead),
        .wdata (rs2_data),
        .rdata (mem_rdata)
    );

    assign pc_plus4 = pc_current + 32'd4;
    assign taken    = Branch && (funct3[0] ? rs1_data != rs2_data
                                           : rs1_data == rs2_data);

    always_comb begin
        pc_next = pc_plus4;
        if (is_jal)       pc_next = pc_current + imm_j;
        else if (is_jalr) pc_next = {alu_result[31:1], 1'b0};
        else if (taken)   pc_next = pc_current + imm_b;
    end

    always_comb begin
        write_back_data = MemtoReg ? mem_rdata : alu_result;
        if (is_jal || is_jalr) write_back_data = pc_plus4;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc_current <= '0;
        else      pc_current <= pc_next;
    end

    // x0 is cleared by reset and never written, so it always reads zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (RegWrite && rd != 5'd0) begin
            regs[rd] <= write_back_data;
        end
    end
endmodule

// File: tb/tb_riscv_single_cycle_processor.sv
// Bench for riscv_single_cycle_processor: directed program plus random
// programs checked against an instruction-level reference model.
module tb_riscv_single_cycle_processor;
    localparam int IW = 256;
    localparam int DW = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    riscv_single_cycle_processor #(.IMEM_WORDS(IW), .DMEM_WORDS(DW)) dut (
        .clk (clk),
        .rst (rst)
    );

    logic [31:0] m_imem [IW];
    logic [31:0] m_dmem [DW];
    logic [31:0] m_reg  [32];
    logic [31:0] m_pc, m_npc, m_wb, m_st_data;
    logic [4:0]  m_rd;
    logic        m_wr, m_st;
    int          m_st_idx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3,
                                          input logic [4:0] d);
        return {f7, r2, r1, f3, d, 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] d,
                                          input logic [6:0] op);
        return {imm, r1, f3, d, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] r2,
                                          input logic [4:0] r1);
        return {imm[11:5], r2, r1, 3'd2, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3);
        return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] d);
        return {imm[20], imm[10:1], imm[11], imm[19:12], d, 7'h6f};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] d);
        return {imm, d, 7'h37};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_prog(input logic [31:0] p[$]);
        for (int i = 0; i < IW; i++) begin
            m_imem[i] = (i < p.size()) ? p[i] : 32'h0;
            dut.IMEM.mem[i] = m_imem[i];
        end
    endtask

    // Reference: one architectural step from the RV32I rules, plain arithmetic.
    task automatic model_eval();
        logic [31:0] ins, a, b, ii, is, ib, ij;
        logic [2:0]  f3;
        ins = m_imem[(m_pc >> 2) % IW];
        f3  = ins[14:12];
        a   = m_reg[ins[19:15]];
        ii  = {{20{ins[31]}}, ins[31:20]};
        is  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ib  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        ij  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        m_rd  = ins[11:7];
        m_npc = m_pc + 4;
        m_wr  = 1'b0;
        m_st  = 1'b0;
        m_wb  = 32'h0;
        m_st_idx  = 0;
        m_st_data = 32'h0;
        case (ins[6:0])
            7'h33, 7'h13: begin
                b = (ins[6:0] == 7'h33) ? m_reg[ins[24:20]] : ii;
                m_wr = 1'b1;
                case (f3)
                    3'd0: m_wb = (ins[6:0] == 7'h33 && ins[30]) ? a - b : a + b;
                    3'd1: m_wb = a << b[4:0];
                    3'd2: m_wb = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    3'd3: m_wb = (a < b) ? 32'd1 : 32'd0;
                    3'd4: m_wb = a ^ b;
                    3'd5: m_wb = ins[30] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
                    3'd6: m_wb = a | b;
                    default: m_wb = a & b;
                endcase
            end
            7'h03: begin
                m_wr = 1'b1;
                m_wb = m_dmem[((a + ii) >> 2) % DW];
            end
            7'h23: begin
                m_st      = 1'b1;
                m_st_idx  = int'(((a + is) >> 2) % DW);
                m_st_data = m_reg[ins[24:20]];
            end
            7'h63: begin
                if ((f3 == 3'd0 && a == m_reg[ins[24:20]]) ||
                    (f3 == 3'd1 && a != m_reg[ins[24:20]]))
                    m_npc = m_pc + ib;
            end
            7'h6f: begin
                m_wr = 1'b1;
                m_wb = m_pc + 4;
                m_npc = m_pc + ij;
            end
            7'h67: begin
                m_wr = 1'b1;
                m_wb = m_pc + 4;
                m_npc = (a + ii) & ~32'd1;
            end
            7'h37: begin
                m_wr = 1'b1;
                m_wb = {ins[31:12], 12'h0};
            end
            default: ;
        endcase
    endtask

    task automatic model_commit();
        if (m_wr && m_rd != 5'd0) m_reg[m_rd] = m_wb;
        if (m_st) m_dmem[m_st_idx] = m_st_data;
        m_pc = m_npc;
    endtask

    task automatic run_cycle();
        model_eval();
        if (m_wr) check("wb", dut.write_back_data, m_wb);
        tick();
        model_commit();
        check("pc", dut.pc_current, m_pc);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        m_pc = 32'h0;
        for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  d, r1, r2;
        logic [2:0]  f3;
        logic [11:0] imm;
        int          off;
        d   = 5'($urandom_range(0, 7));
        r1  = 5'($urandom_range(0, 7));
        r2  = 5'($urandom_range(0, 7));
        f3  = 3'($urandom_range(0, 7));
        imm = 12'($urandom);
        off = $urandom_range(1, 8) * 4;
        if ($urandom_range(0, 1) == 1) off = -off;
        case ($urandom_range(0, 10))
            0, 1: return enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1)
                               ? 7'h20 : 7'h00, r2, r1, f3, d);
            2, 3: begin
                if (f3 == 3'd1) imm = {7'h00, imm[4:0]};
                if (f3 == 3'd5) imm = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, imm[4:0]};
                return enc_i(imm, r1, f3, d, 7'h13);
            end
            4: return enc_i(imm, r1, 3'd2, d, 7'h03);
            5: return enc_s(imm, r2, r1);
            6: return enc_b(13'(off), r2, r1, 3'($urandom_range(0, 1)));
            7: return enc_j(21'(off), d);
            8: return enc_i(12'($urandom_range(0, 255)), 5'd0, 3'd0, d, 7'h67);
            9: return enc_u(20'($urandom), d);
            default: return {25'($urandom), 7'h7f};
        endcase
    endfunction

    initial begin
        logic [31:0] prog[$];

        prog = {32'h00500093,
                enc_i(12'd7, 5'd0, 3'd0, 5'd2, 7'h13),
                enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3),
                enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4),
                enc_b(13'd8, 5'd1, 5'd1, 3'd0),
                enc_i(12'd1, 5'd0, 3'd0, 5'd6, 7'h13),
                enc_b(13'd8, 5'd1, 5'd1, 3'd1),
                enc_s(12'd8, 5'd3, 5'd0),
                enc_i(12'd8, 5'd0, 3'd2, 5'd5, 7'h03),
                enc_i(12'd9, 5'd0, 3'd0, 5'd0, 7'h13),
                32'h00000000,
                enc_u(20'h12345, 5'd7),
                enc_j(21'd8, 5'd8),
                enc_i(12'd1, 5'd0, 3'd0, 5'd6, 7'h13),
                enc_i(12'h041, 5'd0, 3'd0, 5'd9, 7'h67),
                enc_i(12'd1, 5'd0, 3'd0, 5'd6, 7'h13),
                enc_i(12'hfff, 5'd0, 3'd0, 5'd10, 7'h13),
                enc_r(7'h00, 5'd10, 5'd0, 3'd3, 5'd12),
                enc_r(7'h00, 5'd10, 5'd0, 3'd2, 5'd13),
                enc_i(12'h404, 5'd10, 3'd5, 5'd14, 7'h13),
                enc_i(12'h004, 5'd10, 3'd5, 5'd15, 7'h13)};
        load_prog(prog);
        for (int i = 0; i < DW; i++) dut.DMEM.mem[i] = 32'h0;

        #1 rst = 1'b0;
        #2;
        check("rst_pc", dut.pc_current, 32'h0);
        check("rst_x1", dut.regs[1], 32'h0);
        @(negedge clk);
        check("rst_hold_pc", dut.pc_current, 32'h0);
        rst = 1'b1;

        check("addi_regwrite", 32'(dut.RegWrite), 32'd1);
        check("addi_alusrc", 32'(dut.ALUSrc), 32'd1);
        check("addi_alu", dut.alu_result, 32'd5);
        tick();
        check("addi_x1", dut.regs[1], 32'd5);
        check("addi_pc", dut.pc_current, 32'd4);
        tick();
        tick();
        check("add_x3", dut.regs[3], 32'h0000000C);
        tick();
        check("sub_x4", dut.regs[4], 32'hFFFFFFFE);
        check("beq_branch", 32'(dut.Branch), 32'd1);
        tick();
        check("beq_pc", dut.pc_current, 32'h18);
        check("bne_branch", 32'(dut.Branch), 32'd1);
        tick();
        check("bne_pc", dut.pc_current, 32'h1C);
        check("sw_memwrite", 32'(dut.MemWrite), 32'd1);
        tick();
        check("sw_mem", dut.DMEM.mem[2], 32'h0000000C);
        check("lw_memread", 32'(dut.MemRead), 32'd1);
        check("lw_memtoreg", 32'(dut.MemtoReg), 32'd1);
        check("lw_wb", dut.write_back_data, 32'h0000000C);
        tick();
        check("lw_x5", dut.regs[5], 32'h0000000C);
        tick();
        check("x0_zero", dut.regs[0], 32'h0);
        check("nop_regwrite", 32'(dut.RegWrite), 32'd0);
        tick();
        check("nop_pc", dut.pc_current, 32'h2C);
        tick();
        check("lui_x7", dut.regs[7], 32'h12345000);
        tick();
        check("jal_pc", dut.pc_current, 32'h38);
        check("jal_x8", dut.regs[8], 32'h34);
        tick();
        check("jalr_pc", dut.pc_current, 32'h40);
        check("jalr_x9", dut.regs[9], 32'h3C);
        tick();
        tick();
        check("sltu_x12", dut.regs[12], 32'd1);
        tick();
        check("slt_x13", dut.regs[13], 32'd0);
        tick();
        check("srai_x14", dut.regs[14], 32'hFFFFFFFF);
        tick();
        check("srli_x15", dut.regs[15], 32'h0FFFFFFF);
        check("skip_x6", dut.regs[6], 32'h0);

        #2 rst = 1'b0;
        #1;
        check("mid_rst_pc", dut.pc_current, 32'h0);
        check("mid_rst_x1", dut.regs[1], 32'h0);
        check("mid_rst_x15", dut.regs[15], 32'h0);
        tick();
        check("mid_rst_hold", dut.pc_current, 32'h0);
        check("mid_rst_dmem", dut.DMEM.mem[2], 32'h0000000C);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("restart_x1", dut.regs[1], 32'd5);
        check("restart_pc", dut.pc_current, 32'd4);

        for (int p = 0; p < 8; p++) begin
            prog = {};
            for (int k = 0; k < 48; k++) prog.push_back(rand_instr());
            rst = 1'b0;
            load_prog(prog);
            for (int i = 0; i < DW; i++) begin
                m_dmem[i] = $urandom;
                dut.DMEM.mem[i] = m_dmem[i];
            end
            do_reset();
            for (int c = 0; c < 80; c++) run_cycle();
            for (int i = 0; i < 32; i++) check("rnd_reg", dut.regs[i], m_reg[i]);
            for (int i = 0; i < DW; i++) check("rnd_dmem", dut.DMEM.mem[i], m_dmem[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
